// File: rtl/age_ordered_res_station.sv
// Age-ordered reservation station feeding one functional unit.
// Entries hold two source tags with captured/woken readiness, a destination
// tag, a ROB index and an opaque payload. Selection picks the oldest entry
// whose sources are both ready, using a pairwise age matrix.
module age_ordered_res_station #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned NUM_CDB   = 2,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned ROB_W     = 5,
  parameter int unsigned PAYLOAD_W = 96
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [PREG_W-1:0]             alloc_ps1,
  input  logic [PREG_W-1:0]             alloc_ps2,
  input  logic                          alloc_ps1_used,
  input  logic                          alloc_ps2_used,
  input  logic                          alloc_ps1_rdy,
  input  logic                          alloc_ps2_rdy,
  input  logic [PREG_W-1:0]             alloc_pd,
  input  logic [ROB_W-1:0]              alloc_rob_idx,
  input  logic [PAYLOAD_W-1:0]          alloc_payload,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB*PREG_W-1:0]     cdb_pd,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  output logic [PREG_W-1:0]             issue_ps1,
  output logic [PREG_W-1:0]             issue_ps2,
  output logic [PREG_W-1:0]             issue_pd,
  output logic [ROB_W-1:0]              issue_rob_idx,
  output logic [PAYLOAD_W-1:0]          issue_payload,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DEPTH-1:0]                valid_q, valid_d;
  logic [DEPTH-1:0]                rdy1_q, rdy1_d;
  logic [DEPTH-1:0]                rdy2_q, rdy2_d;
  // older_q[i][j] = 1 when entry i was allocated before entry j
  logic [DEPTH-1:0][DEPTH-1:0]     older_q, older_d;
  logic [DEPTH-1:0][PREG_W-1:0]    ps1_q, ps1_d;
  logic [DEPTH-1:0][PREG_W-1:0]    ps2_q, ps2_d;
  logic [DEPTH-1:0][PREG_W-1:0]    pd_q, pd_d;
  logic [DEPTH-1:0][ROB_W-1:0]     rob_q, rob_d;
  logic [DEPTH-1:0][PAYLOAD_W-1:0] pay_q, pay_d;
  logic [CNT_W-1:0]                count_q, count_d;

  logic [IDX_W-1:0] free_idx;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] grant;
  logic [DEPTH-1:0] col;
  logic             alloc_fire;
  logic             issue_fire;

  function automatic logic cdb_hit(input logic [PREG_W-1:0]         tag,
                                   input logic [NUM_CDB-1:0]        v,
                                   input logic [NUM_CDB*PREG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      if (v[k] && (tags[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign alloc_ready = (count_q < DEPTH_C);
  assign count       = count_q;
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign issue_fire  = issue_valid && issue_ready;

  // Lowest-index free slot from registered valid bits
  always_comb begin
    free_idx = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (!valid_q[i-1]) free_idx = IDX_W'(i-1);
    end
  end

  // Oldest-ready select: an entry wins if no ready entry is older than it
  always_comb begin
    ready_vec = valid_q & rdy1_q & rdy2_q;
    grant     = '0;
    col       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) col[j] = older_q[j][i];
      grant[i] = ready_vec[i] && !(|(ready_vec & col));
    end
  end

  // Issue outputs from the one-hot grant, zero when nothing is offered
  always_comb begin
    issue_valid   = (|grant) && !flush;
    issue_ps1     = '0;
    issue_ps2     = '0;
    issue_pd      = '0;
    issue_rob_idx = '0;
    issue_payload = '0;
    if (issue_valid) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (grant[i]) begin
          issue_ps1     = ps1_q[i];
          issue_ps2     = ps2_q[i];
          issue_pd      = pd_q[i];
          issue_rob_idx = rob_q[i];
          issue_payload = pay_q[i];
        end
      end
    end
  end

  // Next state: wakeup, issue invalidation, allocation, then flush override
  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    older_d = older_q;
    ps1_d   = ps1_q;
    ps2_d   = ps2_q;
    pd_d    = pd_q;
    rob_d   = rob_q;
    pay_d   = pay_q;
    count_d = count_q;

    // an unused source is captured as ready, so rdy=0 implies used=1
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !rdy1_q[i] && cdb_hit(ps1_q[i], cdb_valid, cdb_pd)) rdy1_d[i] = 1'b1;
      if (valid_q[i] && !rdy2_q[i] && cdb_hit(ps2_q[i], cdb_valid, cdb_pd)) rdy2_d[i] = 1'b1;
    end

    if (issue_fire) valid_d = valid_d & ~grant;

    if (alloc_fire) begin
      valid_d[free_idx] = 1'b1;
      ps1_d[free_idx]   = alloc_ps1;
      ps2_d[free_idx]   = alloc_ps2;
      pd_d[free_idx]    = alloc_pd;
      rob_d[free_idx]   = alloc_rob_idx;
      pay_d[free_idx]   = alloc_payload;
      rdy1_d[free_idx]  = !alloc_ps1_used || alloc_ps1_rdy ||
                          cdb_hit(alloc_ps1, cdb_valid, cdb_pd);
      rdy2_d[free_idx]  = !alloc_ps2_used || alloc_ps2_rdy ||
                          cdb_hit(alloc_ps2, cdb_valid, cdb_pd);
      // new entry is younger than every other slot; stale bits toward
      // invalid slots are harmless and are overwritten when those allocate
      older_d[free_idx] = '0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        older_d[j][free_idx] = (IDX_W'(j) != free_idx);
      end
    end

    case ({alloc_fire, issue_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      valid_d = '0;
      older_d = '0;
      count_d = '0;
    end
  end

  // State registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      older_q <= '0;
      ps1_q   <= '0;
      ps2_q   <= '0;
      pd_q    <= '0;
      rob_q   <= '0;
      pay_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      older_q <= older_d;
      ps1_q   <= ps1_d;
      ps2_q   <= ps2_d;
      pd_q    <= pd_d;
      rob_q   <= rob_d;
      pay_q   <= pay_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_age_ordered_res_station.sv
// Bench for age_ordered_res_station: a cycle-level reference model keeps
// pending entries in allocation order; each cycle the oldest ready one is the
// expected issue and is popped on handshake.
module tb_age_ordered_res_station;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned NUM_CDB   = 2;
  localparam int unsigned PREG_W    = 6;
  localparam int unsigned ROB_W     = 5;
  localparam int unsigned PAYLOAD_W = 96;

  logic                      clk;
  logic                      rst;
  logic                      flush;
  logic                      alloc_valid;
  logic                      alloc_ready;
  logic [PREG_W-1:0]         alloc_ps1, alloc_ps2, alloc_pd;
  logic                      alloc_ps1_used, alloc_ps2_used;
  logic                      alloc_ps1_rdy, alloc_ps2_rdy;
  logic [ROB_W-1:0]          alloc_rob_idx;
  logic [PAYLOAD_W-1:0]      alloc_payload;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*PREG_W-1:0] cdb_pd;
  logic                      issue_valid;
  logic                      issue_ready;
  logic [PREG_W-1:0]         issue_ps1, issue_ps2, issue_pd;
  logic [ROB_W-1:0]          issue_rob_idx;
  logic [PAYLOAD_W-1:0]      issue_payload;
  logic [$clog2(DEPTH+1)-1:0] count;

  age_ordered_res_station #(
    .DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .PREG_W(PREG_W),
    .ROB_W(ROB_W), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_ps1(alloc_ps1), .alloc_ps2(alloc_ps2),
    .alloc_ps1_used(alloc_ps1_used), .alloc_ps2_used(alloc_ps2_used),
    .alloc_ps1_rdy(alloc_ps1_rdy), .alloc_ps2_rdy(alloc_ps2_rdy),
    .alloc_pd(alloc_pd), .alloc_rob_idx(alloc_rob_idx), .alloc_payload(alloc_payload),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_ps1(issue_ps1), .issue_ps2(issue_ps2), .issue_pd(issue_pd),
    .issue_rob_idx(issue_rob_idx), .issue_payload(issue_payload),
    .count(count)
  );

  typedef struct {
    logic [PREG_W-1:0]    ps1, ps2, pd;
    logic [ROB_W-1:0]     rob;
    logic [PAYLOAD_W-1:0] pl;
    logic                 r1, r2;
  } ent_t;

  ent_t mq[$];
  int   checks   = 0;
  int   failures = 0;
  int   issued   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit tb_hit(input logic [PREG_W-1:0] tag);
    bit h = 0;
    for (int k = 0; k < NUM_CDB; k++)
      if (cdb_valid[k] && cdb_pd[k*PREG_W +: PREG_W] == tag) h = 1;
    return h;
  endfunction

  // Compare DUT against model for the current cycle, then advance both.
  task automatic cycle();
    int   sel;
    bit   ev, ifire, afire;
    ent_t n;
    #1;
    sel = -1;
    foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
    ev = (sel >= 0) && !flush;
    check("count", 128'(count), 128'(mq.size()));
    check("alloc_ready", 128'(alloc_ready), 128'(mq.size() < DEPTH));
    check("issue_valid", 128'(issue_valid), 128'(ev));
    if (issue_valid && ev) begin
      check("issue_ps1", 128'(issue_ps1), 128'(mq[sel].ps1));
      check("issue_ps2", 128'(issue_ps2), 128'(mq[sel].ps2));
      check("issue_pd", 128'(issue_pd), 128'(mq[sel].pd));
      check("issue_rob", 128'(issue_rob_idx), 128'(mq[sel].rob));
      check("issue_payload", 128'(issue_payload), 128'(mq[sel].pl));
    end else if (!issue_valid) begin
      check("issue_zero", 128'({issue_ps1, issue_ps2, issue_pd, issue_rob_idx, issue_payload}), 128'(0));
    end
    ifire = ev && issue_ready;
    afire = alloc_valid && (mq.size() < DEPTH) && !flush;
    n.ps1 = alloc_ps1; n.ps2 = alloc_ps2; n.pd = alloc_pd;
    n.rob = alloc_rob_idx; n.pl = alloc_payload;
    n.r1  = !alloc_ps1_used || alloc_ps1_rdy || tb_hit(alloc_ps1);
    n.r2  = !alloc_ps2_used || alloc_ps2_rdy || tb_hit(alloc_ps2);
    if (flush) mq.delete();
    else begin
      foreach (mq[i]) begin
        if (tb_hit(mq[i].ps1)) mq[i].r1 = 1'b1;
        if (tb_hit(mq[i].ps2)) mq[i].r2 = 1'b1;
      end
      if (ifire) begin mq.delete(sel); issued++; end
      if (afire) mq.push_back(n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alloc(input logic [PREG_W-1:0] p1, input logic u1, input logic r1,
                             input logic [PREG_W-1:0] p2, input logic u2, input logic r2,
                             input logic [4:0] id);
    alloc_valid    = 1'b1;
    alloc_ps1      = p1; alloc_ps1_used = u1; alloc_ps1_rdy = r1;
    alloc_ps2      = p2; alloc_ps2_used = u2; alloc_ps2_rdy = r2;
    alloc_pd       = PREG_W'(id + 32);
    alloc_rob_idx  = id;
    alloc_payload  = {$urandom, $urandom, $urandom};
  endtask

  task automatic do_alloc(input logic [PREG_W-1:0] p1, input logic u1, input logic r1,
                          input logic [PREG_W-1:0] p2, input logic u2, input logic r2,
                          input logic [4:0] id);
    drive_alloc(p1, u1, r1, p2, u2, r2, id);
    cycle();
    alloc_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_cdb(input int port, input logic [PREG_W-1:0] tag);
    cdb_valid = '0;
    cdb_valid[port] = 1'b1;
    cdb_pd[port*PREG_W +: PREG_W] = tag;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; alloc_valid = 1'b0;
    alloc_ps1 = '0; alloc_ps2 = '0; alloc_pd = '0;
    alloc_ps1_used = 1'b0; alloc_ps2_used = 1'b0;
    alloc_ps1_rdy = 1'b0; alloc_ps2_rdy = 1'b0;
    alloc_rob_idx = '0; alloc_payload = '0;
    cdb_valid = '0; cdb_pd = '0; issue_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 128'(count), 128'(0));
    check("rst_alloc_ready", 128'(alloc_ready), 128'(1));
    check("rst_issue_valid", 128'(issue_valid), 128'(0));
    rst = 1'b1;
    idle(2);

    // same-cycle CDB bypass on ps2
    set_cdb(0, 12);
    do_alloc(5, 1, 1, 12, 1, 0, 1);
    cdb_valid = '0;
    idle(1);
    issue_ready = 1'b1; idle(1); issue_ready = 1'b0;
    check("bypass_issued", 128'(issued), 128'(1));
    idle(1);

    // age order: A(ps1=3) B(ready) C(ps1=3), C lands in B's freed slot
    issue_ready = 1'b1;
    do_alloc(3, 1, 0, 0, 0, 0, 2);
    do_alloc(4, 1, 1, 0, 0, 0, 3);
    idle(1);
    do_alloc(3, 1, 0, 0, 0, 0, 4);
    set_cdb(0, 3); idle(1); cdb_valid = '0;
    idle(3);
    check("age_issued", 128'(issued), 128'(4));
    issue_ready = 1'b0;

    // backpressure on a single ready entry
    do_alloc(0, 1, 1, 1, 1, 1, 5);
    idle(4);
    issue_ready = 1'b1; idle(1); issue_ready = 1'b0;
    idle(1);

    // fill with unready ps1=7, ninth offer ignored, wake via port 1
    for (int i = 0; i < DEPTH; i++) do_alloc(7, 1, 0, 0, 0, 0, 5'(8 + i));
    check("full_count", 128'(count), 128'(DEPTH));
    do_alloc(1, 0, 0, 2, 0, 0, 20);
    set_cdb(1, 7); idle(1); cdb_valid = '0;
    issue_ready = 1'b1;
    idle(DEPTH + 2);
    check("fill_drained", 128'(count), 128'(0));
    issue_ready = 1'b0;

    // flush with a concurrent alloc
    for (int i = 0; i < 3; i++) do_alloc(9, 1, 0, 0, 0, 0, 5'(21 + i));
    flush = 1'b1;
    drive_alloc(0, 0, 0, 0, 0, 0, 24);
    cycle();
    flush = 1'b0; alloc_valid = 1'b0;
    idle(2);

    // asynchronous reset mid-traffic with 5 entries held
    for (int i = 0; i < 5; i++) do_alloc(5'(i), 1, (i % 2) == 0, 0, 0, 0, 5'(25 + i));
    rst = 1'b0;
    #2;
    check("mid_rst_issue_valid", 128'(issue_valid), 128'(0));
    check("mid_rst_alloc_ready", 128'(alloc_ready), 128'(1));
    check("mid_rst_count", 128'(count), 128'(0));
    mq.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_alloc(1, 1, 1, 2, 0, 0, 30);
    issue_ready = 1'b1; idle(2); issue_ready = 1'b0;

    // mixed random traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) != 0)
        drive_alloc(PREG_W'($urandom_range(15)), 1'($urandom), 1'($urandom),
                    PREG_W'($urandom_range(15)), 1'($urandom), 1'($urandom),
                    5'($urandom));
      else alloc_valid = 1'b0;
      cdb_valid = NUM_CDB'($urandom);
      for (int k = 0; k < NUM_CDB; k++) cdb_pd[k*PREG_W +: PREG_W] = PREG_W'($urandom_range(15));
      issue_ready = 1'($urandom);
      flush = ($urandom_range(40) == 0);
      cycle();
    end
    alloc_valid = 1'b0; cdb_valid = '0; flush = 1'b0; issue_ready = 1'b0;
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
